// File: rtl/pll_drp_pkg.sv
// Shared encodings for the PLL dynamic-reconfiguration master: port opcodes,
// FSM states and PLL register map.
package pll_drp_pkg;

  localparam logic [1:0] OPC_NOP     = 2'b00;
  localparam logic [1:0] OPC_WRITE   = 2'b01;
  localparam logic [1:0] OPC_READ    = 2'b10;
  localparam logic [1:0] OPC_SETADDR = 2'b11;

  localparam logic [7:0] REG_IDIV  = 8'h00;
  localparam logic [7:0] REG_FBDIV = 8'h01;
  localparam logic [7:0] REG_ODIV0 = 8'h02;
  localparam logic [7:0] REG_ODIV1 = 8'h03;
  localparam logic [7:0] REG_ODIV2 = 8'h04;
  localparam logic [7:0] REG_ODIV3 = 8'h05;
  localparam logic [7:0] REG_ODIV4 = 8'h06;
  localparam logic [7:0] REG_ODIV5 = 8'h07;
  localparam logic [7:0] REG_ODIV6 = 8'h08;
  localparam logic [7:0] REG_MDIV  = 8'h09;

  typedef enum logic [3:0] {
    S_IDLE, S_SETADDR, S_WRITE, S_WNOP, S_READ,
    S_CAPTURE, S_HOLDOFF, S_WAITLOCK, S_DONE
  } drp_state_e;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } drp_req_t;

endpackage

// File: rtl/pll_drp_clkgen.sv
// md_clk divider: toggles every MDCLK_DIV clk cycles while run is high, parked
// low otherwise; rise/fall ticks flag the cycle before the corresponding edge.
module pll_drp_clkgen #(
  parameter int MDCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic md_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(MDCLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick      = run && (cnt == CW'(MDCLK_DIV - 1));
  assign rise_tick = tick && !md_clk;
  assign fall_tick = tick && md_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      md_clk <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      md_clk <= 1'b0;
    end else if (tick) begin
      cnt    <= '0;
      md_clk <= ~md_clk;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pll_drp_master.sv
// PLL reconfiguration-port initiator: turns single register read/write
// requests into SETADDR/WRITE/READ phases and waits for re-lock after writes.
module pll_drp_master
  import pll_drp_pkg::*;
#(
  parameter int MDCLK_DIV    = 4,
  parameter int LOCK_HOLDOFF = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       busy,
  input  logic       pll_lock,
  output logic       md_clk,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo
);

  localparam int TW_TO = $clog2(LOCK_TIMEOUT + 1);
  localparam int TW_HO = $clog2(LOCK_HOLDOFF + 1);
  localparam int TW    = (TW_TO > TW_HO) ? TW_TO : TW_HO;

  drp_state_e    state, nxt;
  drp_req_t      req_q;
  logic [TW-1:0] tmr;
  logic [1:0]    lock_pipe;
  logic          lock_s, hold_last, tmo, to_q;
  logic          run, rise_tick, fall_tick;

  assign run = (state == S_SETADDR) || (state == S_WRITE) || (state == S_WNOP) ||
               (state == S_READ) || (state == S_CAPTURE);

  pll_drp_clkgen #(.MDCLK_DIV(MDCLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .md_clk    (md_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign hold_last = (state == S_HOLDOFF) && (tmr == TW'(LOCK_HOLDOFF - 1));
  assign tmo       = tmr >= TW'(LOCK_TIMEOUT - 1);
  assign lock_s    = lock_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    md_opc = OPC_NOP;
    md_wdi = 8'h00;
    unique case (state)
      S_IDLE:     if (req_valid) nxt = S_SETADDR;
      S_SETADDR: begin
        md_opc = OPC_SETADDR;
        md_wdi = req_q.addr;
        if (fall_tick) nxt = req_q.we ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        md_opc = OPC_WRITE;
        md_wdi = req_q.wdata;
        if (fall_tick) nxt = S_WNOP;
      end
      S_WNOP:     if (fall_tick) nxt = S_HOLDOFF;
      S_READ: begin
        md_opc = OPC_READ;
        if (fall_tick) nxt = S_CAPTURE;
      end
      S_CAPTURE:  if (fall_tick) nxt = S_DONE;
      S_HOLDOFF:  if (hold_last) nxt = S_WAITLOCK;
      S_WAITLOCK: if (lock_s || tmo) nxt = S_DONE;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Timer is preloaded to 1 on holdoff exit so the timeout lands exactly
  // LOCK_TIMEOUT cycles after holdoff. The lock synchroniser is held clear
  // until the last holdoff cycle so only post-write lock samples count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      tmr       <= '0;
      lock_pipe <= '0;
      rsp_rdata <= 8'h00;
      to_q      <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
      if (hold_last)                    tmr <= TW'(1);
      else if (state == S_HOLDOFF || state == S_WAITLOCK) tmr <= tmr + 1'b1;
      else                              tmr <= '0;
      if (hold_last || state == S_WAITLOCK) lock_pipe <= {lock_pipe[0], pll_lock};
      else                              lock_pipe <= '0;
      if (state == S_CAPTURE && rise_tick) rsp_rdata <= md_rdo;
      if (state == S_WAITLOCK)          to_q <= !lock_s;
      else if (state == S_IDLE)         to_q <= 1'b0;
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rsp_valid   = (state == S_DONE);
  assign rsp_timeout = (state == S_DONE) && to_q;
  assign md_ainc     = 1'b0;

endmodule

// File: tb/tb_pll_drp_master.sv
// Directed bench for pll_drp_master: reads, writes with/without re-lock,
// timeout, back-to-back requests and asynchronous reset mid-write.
module tb_pll_drp_master;
  import pll_drp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  logic       pll_lock;
  logic       md_clk, md_ainc;
  logic [1:0] md_opc;
  logic [7:0] md_wdi;
  logic [7:0] md_rdo;

  int n_tests = 0;
  int n_fail  = 0;

  // trace of one transaction, indexed by cycles since the accept cycle (0)
  logic [1:0] opc_tr [0:511];
  logic [7:0] wdi_tr [0:511];
  logic       mclk_tr[0:511];
  logic       busy_tr[0:511];
  int         lat_g;
  logic [7:0] rd_g;
  logic       to_g;

  assign md_rdo = 8'hC3;

  always #5 clk = ~clk;

  pll_drp_master #(.MDCLK_DIV(2), .LOCK_HOLDOFF(16), .LOCK_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .busy(busy), .pll_lock(pll_lock),
    .md_clk(md_clk), .md_opc(md_opc), .md_ainc(md_ainc),
    .md_wdi(md_wdi), .md_rdo(md_rdo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request; lock drops/rises at the given trace indices (-1 = never).
  task automatic txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                     input int drop_at, input int rise_at);
    int lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      req_valid = 1'b0;
      if (lat == drop_at) pll_lock = 1'b0;
      if (lat == rise_at) pll_lock = 1'b1;
      opc_tr[lat] = md_opc; wdi_tr[lat] = md_wdi;
      mclk_tr[lat] = md_clk; busy_tr[lat] = busy;
    end while (!rsp_valid && lat < 400);
    lat_g = lat; rd_g = rsp_rdata; to_g = rsp_timeout;
    if (!rsp_valid) chk("rsp_valid_bound", 32'(lat), 32'hFFFF);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; pll_lock = 1'b1;
    #12;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_md_clk", 32'(md_clk), 0);
    chk("rst_md_opc", 32'(md_opc), 0);
    chk("rst_md_ainc", 32'(md_ainc), 0);
    chk("rst_md_wdi", 32'(md_wdi), 0);
    #10 rst_n = 1'b1;

    // read 0x21: 4-cycle phases 11/10/00, response in cycle 13
    txn(1'b0, 8'h21, 8'h00, -1, -1);
    chk("rd_lat", 32'(lat_g), 13);
    chk("rd_opc_sa0", 32'(opc_tr[1]), 3);
    chk("rd_wdi_sa", 32'(wdi_tr[1]), 8'h21);
    chk("rd_opc_sa3", 32'(opc_tr[4]), 3);
    chk("rd_mclk_lo", 32'(mclk_tr[1]), 0);
    chk("rd_mclk_hi", 32'(mclk_tr[3]), 1);
    chk("rd_opc_rd0", 32'(opc_tr[5]), 2);
    chk("rd_opc_rd3", 32'(opc_tr[8]), 2);
    chk("rd_opc_cap", 32'(opc_tr[9]), 0);
    chk("rd_busy_done", 32'(busy_tr[13]), 1);
    chk("rd_rdata", 32'(rd_g), 8'hC3);
    chk("rd_timeout", 32'(to_g), 0);
    @(posedge clk); #1;
    chk("rd_after_busy", 32'(busy), 0);
    chk("rd_after_ready", 32'(req_ready), 1);
    chk("rd_rdata_held", 32'(rsp_rdata), 8'hC3);

    // write 0x10<-0x5A, lock drops in cycle 11 and returns in cycle 51
    txn(1'b1, 8'h10, 8'h5A, 11, 51);
    chk("wr_opc_sa", 32'(opc_tr[1]), 3);
    chk("wr_wdi_addr", 32'(wdi_tr[1]), 8'h10);
    chk("wr_opc_wr", 32'(opc_tr[5]), 1);
    chk("wr_wdi_data", 32'(wdi_tr[5]), 8'h5A);
    chk("wr_opc_nop", 32'(opc_tr[9]), 0);
    chk("wr_mclk_stopped", 32'(mclk_tr[13]), 0);
    chk("wr_relock_lat", 32'(lat_g), 54);
    chk("wr_relock_to", 32'(to_g), 0);

    // lock never drops: holdoff ends in cycle 28, response 3 cycles later
    txn(1'b1, 8'h02, 8'h11, -1, -1);
    chk("wr_steady_lat", 32'(lat_g), 31);
    chk("wr_steady_to", 32'(to_g), 0);

    // lock stuck low: response 100 cycles after holdoff end
    pll_lock = 1'b0;
    txn(1'b1, 8'h03, 8'h22, -1, -1);
    chk("wr_tmo_lat", 32'(lat_g), 128);
    chk("wr_tmo_flag", 32'(to_g), 1);
    pll_lock = 1'b1;

    // back-to-back with req_valid held high
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      if (req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("b2b_ready_low", 32'(bad), 0);
    chk("b2b_first_done", 32'(rsp_valid), 1);
    chk("b2b_done_opc", 32'(md_opc), 0);
    req_addr = 8'h06;
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(req_ready), 1);
    chk("b2b_idle_opc", 32'(md_opc), 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_second_opc", 32'(md_opc), 3);
    chk("b2b_second_wdi", 32'(md_wdi), 8'h06);
    chk("b2b_second_busy", 32'(busy), 1);
    bad = 0;
    while (!rsp_valid && bad < 100) begin @(posedge clk); #1; bad++; end
    chk("b2b_second_done", 32'(rsp_valid), 1);

    // asynchronous reset in the WRITE phase
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h07; req_wdata = 8'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_pre_opc", 32'(md_opc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_md_clk", 32'(md_clk), 0);
    chk("rst_mid_md_opc", 32'(md_opc), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_md_wdi", 32'(md_wdi), 0);
    #2 rst_n = 1'b1;
    txn(1'b0, 8'h33, 8'h00, -1, -1);
    chk("post_rst_opc", 32'(opc_tr[1]), 3);
    chk("post_rst_wdi", 32'(wdi_tr[1]), 8'h33);
    chk("post_rst_lat", 32'(lat_g), 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
